steer_quad_gen: RTL and testbench
=================================

# steer_quad_gen

Multi-channel digital-joystick-to-quadrature steering encoder with optional hold-time acceleration. Each channel converts left/right button levels into a 2-bit Gray-code quadrature pair (A/B) that feeds a game core's steering-wheel inputs. It is the parametrised successor of the single-channel fixed-rate joystick-to-quadrature converter. It sits between the joystick mux and the arcade core, clocked by the core's pixel-rate clock.

## Interface
- CHANNELS, 2, number of independent steering channels (1..8)
- DIV_W, 16, width of the step-period input
- ACCEL_HOLD, 4, steps taken at one rate before the rate doubles (1..255)
- ACCEL_MAX_SHIFT, 3, maximum right-shift applied to the period (0..DIV_W-1)

Ports:
- CLK  in  1  core clock; all logic on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- clkdiv  in  DIV_W  base step period in CLK cycles; 0 is treated as 1
- left  in  CHANNELS  per-channel left request, level, asynchronous to CLK
- right  in  CHANNELS  per-channel right request, level, asynchronous to CLK
- steer  out  2*CHANNELS  channel i drives {A,B} on [2i+1:2i]; registered
- step_pulse  out  CHANNELS  one-cycle strobe on each phase advance of channel i; registered

## Operation
- left and right pass through a 2-flop synchroniser per bit. Only the synchronised values are used below.
- Per-channel direction is decoded from the synchronised inputs:
  - right only → CW
  - left only → CCW
  - both or neither → IDLE
- Each channel holds a 2-bit phase counter ph. steer = {ph[1], ph[1]^ph[0]}, giving the sequence 00→01→11→10→00 for CW.
  - CW increments ph; CCW decrements ph.
  - Phase wraps modulo 4 in both directions.
- Each channel has a DIV_W-bit down-counter cnt, a shift register sh (0..ACCEL_MAX_SHIFT) and a hold counter hc (0..ACCEL_HOLD-1).
- Effective period: P = max(1, max(clkdiv,1) >> sh).
- Channel states:
  - IDLE: cnt=0, sh=0, hc=0. ph is held and steer is frozen. On entry to CW/CCW, cnt loads P-1 with sh=0.
  - RUN: while the direction is unchanged and cnt≠0, cnt decrements. When cnt=0, the channel advances ph one step, pulses step_pulse, updates hc/sh, and reloads cnt with P-1 computed from the updated sh.
  - Direction reversal (CW↔CCW in one cycle): treated as a fresh entry. sh and hc clear, cnt reloads P-1, and no step is issued that cycle.
  - RUN→IDLE: all counters clear; ph is retained.
- Acceleration update on each step: if hc=ACCEL_HOLD-1, then hc←0 and sh←min(sh+1, ACCEL_MAX_SHIFT); otherwise hc←hc+1.
- A clkdiv change takes effect at the next reload only. An in-flight count is not modified.
- Channels are fully independent. Simultaneous steps on several channels are allowed.

## Timing
- Reset values: steer=0, step_pulse=0, and all sync flops, ph, cnt, sh and hc are 0.
- Reset is asynchronous on assertion and is released synchronously through the flops' normal edge behaviour.
- Input latency:
  - A level stable before edge 0 is seen as direction at edge 2.
  - cnt loads at edge 3.
  - The first step_pulse and steer change occur at edge 3+P.
- Subsequent steps occur every P cycles at the current rate. steer changes on the same edge that step_pulse rises.
- Release latency: steps stop within 2 cycles of the input falling. A step already due at the release edge is still issued.
- step_pulse is never high for two consecutive cycles unless P=1.

## Configuration
- STEER_QUAD_ACCEL_EN defined: acceleration as described above.
- STEER_QUAD_ACCEL_EN undefined:
  - sh and hc are not instantiated, and P = max(clkdiv,1) always.
  - ACCEL_HOLD and ACCEL_MAX_SHIFT are ignored.
  - All other behaviour is identical.

## Test plan
- Reset and hold: with Reset_n low, toggle inputs → steer=0 and step_pulse=0 throughout. Pulse Reset_n low mid-run → steer returns to 0 asynchronously.
- Basic CW, macro off: CHANNELS=1, clkdiv=4, right held from before edge 0 → steps at edges 7, 11, 15, 19 with steer 01, 11, 10, 00.
- CCW with wrap: clkdiv=2, left held → steer sequence 10, 11, 01, 00, 10. Both left and right asserted → no steps, steer frozen.
- Acceleration, macro on: clkdiv=16, ACCEL_HOLD=2, ACCEL_MAX_SHIFT=2, right held → step intervals 16, 16, 8, 8, 4, 4, 4. Release and re-press → interval returns to 16.
- Reversal: after 3 accelerated CW steps, switch to left in one cycle → no step on the switch cycle, next step P=16 cycles after reload, phase decrements.
- Multi-channel and clkdiv edge cases: CHANNELS=2, ch0 CW with clkdiv=3 and ch1 CCW concurrently → independent step_pulses, coincident steps both issued. clkdiv=0 → step every cycle.

Source files
------------

// File: rtl/steer_quad_gen.sv
// Joystick-to-quadrature steering encoder, CHANNELS independent lanes; STEER_QUAD_ACCEL_EN enables hold-time rate doubling.
// Latency: input level to direction 2 edges, counter load edge 3, first step edge 3+P.
// Backpressure: none, free-running; steps are strobed and cannot be stalled.
module steer_quad_gen #(
  parameter int CHANNELS        = 2,
  parameter int DIV_W           = 16,
  parameter int ACCEL_HOLD      = 4,
  parameter int ACCEL_MAX_SHIFT = 3
) (
  input  logic                    CLK,
  input  logic                    Reset_n,
  input  logic [DIV_W-1:0]        clkdiv,
  input  logic [CHANNELS-1:0]     left,
  input  logic [CHANNELS-1:0]     right,
  output logic [2*CHANNELS-1:0]   steer,
  output logic [CHANNELS-1:0]     step_pulse
);

  localparam logic [1:0] DIR_IDLE = 2'd0;
  localparam logic [1:0] DIR_CW   = 2'd1;
  localparam logic [1:0] DIR_CCW  = 2'd2;

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [CHANNELS-1:0] left_s1, left_s2, right_s1, right_s2;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      left_s1  <= '0;
      left_s2  <= '0;
      right_s1 <= '0;
      right_s2 <= '0;
    end else begin
      left_s1  <= left;
      left_s2  <= left_s1;
      right_s1 <= right;
      right_s2 <= right_s1;
    end
  end

  // Reload value is P-1 where P = max(1, max(div,1) >> shamt).
  function automatic logic [DIV_W-1:0] reload_val(input logic [DIV_W-1:0] div,
                                                  input logic [7:0]       shamt);
    logic [DIV_W-1:0] base;
    logic [DIV_W-1:0] per;
    base = (div == '0) ? DIV_ONE : div;
    per  = base >> shamt;
    if (per == '0) per = DIV_ONE;
    return per - DIV_ONE;
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]       dir_d, dir_q, run_q, ph_q, ph_step, steer_q;
    logic [DIV_W-1:0] cnt_q;
    logic             pulse_q, idle_in, due, do_load, do_step;
    logic [7:0]       sh_nxt;

    always_comb begin
      dir_d = DIR_IDLE;
      if (right_s2[i] && !left_s2[i])      dir_d = DIR_CW;
      else if (left_s2[i] && !right_s2[i]) dir_d = DIR_CCW;
    end

    assign idle_in = (dir_q == DIR_IDLE);
    assign due     = (cnt_q == '0);
    // A new or reversed direction restarts timing without stepping.
    assign do_load = !idle_in && (dir_q != run_q);
    assign do_step = (run_q != DIR_IDLE) && due && (idle_in || (dir_q == run_q));
    assign ph_step = (run_q == DIR_CW) ? ph_q + 2'd1 : ph_q - 2'd1;

`ifdef STEER_QUAD_ACCEL_EN
    logic [7:0] sh_q, hc_q, hc_nxt;

    always_comb begin
      hc_nxt = hc_q + 8'd1;
      sh_nxt = sh_q;
      if (hc_q == 8'(ACCEL_HOLD - 1)) begin
        hc_nxt = '0;
        if (sh_q < 8'(ACCEL_MAX_SHIFT)) sh_nxt = sh_q + 8'd1;
      end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
        sh_q <= '0;
        hc_q <= '0;
      end else if (idle_in || do_load) begin
        sh_q <= '0;
        hc_q <= '0;
      end else if (do_step) begin
        sh_q <= sh_nxt;
        hc_q <= hc_nxt;
      end
    end
`else
    assign sh_nxt = '0;
`endif

    always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
        dir_q   <= DIR_IDLE;
        run_q   <= DIR_IDLE;
        ph_q    <= '0;
        steer_q <= '0;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        dir_q   <= dir_d;
        pulse_q <= do_step;
        if (do_step) begin
          ph_q    <= ph_step;
          steer_q <= {ph_step[1], ph_step[1] ^ ph_step[0]};
        end
        if (idle_in) begin
          run_q <= DIR_IDLE;
          cnt_q <= '0;
        end else if (do_load) begin
          run_q <= dir_q;
          cnt_q <= reload_val(clkdiv, 8'd0);
        end else if (due) begin
          cnt_q <= reload_val(clkdiv, sh_nxt);
        end else begin
          cnt_q <= cnt_q - DIV_ONE;
        end
      end
    end

    assign steer[2*i +: 2] = steer_q;
    assign step_pulse[i]   = pulse_q;
  end

endmodule

// File: tb/tb_steer_quad_gen.sv
// Scoreboard bench for steer_quad_gen: expected steps queued per channel, monitor checks edge and steer code.
module tb_steer_quad_gen;
  localparam int CH    = 2;
  localparam int DW    = 16;
  localparam int HOLD  = 2;
  localparam int MAXSH = 2;

  logic          CLK = 1'b0;
  logic          Reset_n = 1'b0;
  logic [DW-1:0] clkdiv = '0;
  logic [CH-1:0] left = '0;
  logic [CH-1:0] right = '0;
  logic [2*CH-1:0] steer;
  logic [CH-1:0] step_pulse;

  steer_quad_gen #(
    .CHANNELS(CH), .DIV_W(DW), .ACCEL_HOLD(HOLD), .ACCEL_MAX_SHIFT(MAXSH)
  ) dut (
    .CLK(CLK), .Reset_n(Reset_n), .clkdiv(clkdiv), .left(left), .right(right),
    .steer(steer), .step_pulse(step_pulse)
  );

  always #5 CLK = ~CLK;

  int ecount = 0;
  always @(posedge CLK) ecount <= ecount + 1;

  typedef struct {
    int         t;
    logic [1:0] s;
  } ev_t;

  ev_t        evq [CH][$];
  logic [1:0] ph_m  [CH] = '{2'd0, 2'd0};
  logic [1:0] cur_s [CH] = '{2'd0, 2'd0};
  int tests = 0;
  int fails = 0;

`ifdef STEER_QUAD_ACCEL_EN
  int acc_t[7] = '{20, 36, 44, 52, 56, 60, 64};
  int rev_t[3] = '{20, 36, 44};
`else
  int acc_t[3] = '{20, 36, 52};
  int rev_t[2] = '{20, 36};
`endif

  function automatic logic [1:0] gray(input logic [1:0] ph);
    return {ph[1], ph[1] ^ ph[0]};
  endfunction

  function automatic int per(input int sh);
    int b, p;
    b = (clkdiv == 0) ? 1 : int'(clkdiv);
    p = b >> sh;
    return (p == 0) ? 1 : p;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_step(input int ch, input int t, input bit cw);
    ev_t e;
    ph_m[ch] = cw ? ph_m[ch] + 2'd1 : ph_m[ch] - 2'd1;
    e.t = t;
    e.s = gray(ph_m[ch]);
    evq[ch].push_back(e);
  endtask

  // Reference stepping model from a load edge to the edge where the channel sees release.
  task automatic sched(input int ch, input bit cw, input int start, input int stop, input bit incl);
    int t, sh, hc;
    t = start; sh = 0; hc = 0;
    forever begin
      t += per(sh);
      if (t > stop || (t == stop && !incl)) break;
      push_step(ch, t, cw);
`ifdef STEER_QUAD_ACCEL_EN
      if (hc == HOLD - 1) begin
        hc = 0;
        if (sh < MAXSH) sh++;
      end else begin
        hc++;
      end
`endif
    end
  endtask

  task automatic wait_edge(input int e);
    while (ecount < e) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (Reset_n) begin
      for (int c = 0; c < CH; c++) begin
        if (step_pulse[c]) begin
          tests++;
          if (evq[c].size() == 0) begin
            fails++;
            $display("FAIL unexpected_step ch%0d: edge %0d steer %b, expected no step", c, ecount, steer[2*c +: 2]);
          end else begin
            ev_t e;
            e = evq[c].pop_front();
            if (e.t != ecount || e.s != steer[2*c +: 2]) begin
              fails++;
              $display("FAIL step ch%0d: got edge %0d steer %b, expected edge %0d steer %b",
                       c, ecount, steer[2*c +: 2], e.t, e.s);
            end
            cur_s[c] = e.s;
          end
        end else if (evq[c].size() > 0 && evq[c][0].t <= ecount) begin
          ev_t e;
          e = evq[c].pop_front();
          tests++;
          fails++;
          $display("FAIL missed_step ch%0d: no pulse by edge %0d, expected at edge %0d", c, ecount, e.t);
          cur_s[c] = e.s;
        end
        tests++;
        if (steer[2*c +: 2] != cur_s[c]) begin
          fails++;
          $display("FAIL steer_hold ch%0d: got %b expected %b at edge %0d", c, steer[2*c +: 2], cur_s[c], ecount);
        end
      end
    end
  end

  initial begin
    int k;

    // Reset held: inputs toggle, outputs must stay 0.
    clkdiv = 16'd1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      left  = CH'($urandom);
      right = CH'($urandom);
      #1;
      check("reset_steer", int'(steer), 0);
      check("reset_pulse", int'(step_pulse), 0);
    end
    left = '0; right = '0;
    @(negedge CLK);
    Reset_n = 1'b1;
    repeat (6) @(negedge CLK);

    // Basic CW, clkdiv=4.
    clkdiv = 16'd4;
    k = ecount; right = 2'b01;
`ifdef STEER_QUAD_ACCEL_EN
    sched(0, 1'b1, k + 4, k + 20, 1'b1);
`else
    push_step(0, k + 8, 1'b1);
    push_step(0, k + 12, 1'b1);
    push_step(0, k + 16, 1'b1);
    push_step(0, k + 20, 1'b1);
`endif
    wait_edge(k + 16); right = '0;
    repeat (10) @(negedge CLK);

    // CCW with wrap, clkdiv=2.
    clkdiv = 16'd2;
    k = ecount; left = 2'b01;
`ifdef STEER_QUAD_ACCEL_EN
    sched(0, 1'b0, k + 4, k + 14, 1'b1);
`else
    for (int i = 0; i < 5; i++) push_step(0, k + 6 + 2*i, 1'b0);
`endif
    wait_edge(k + 10); left = '0;
    repeat (10) @(negedge CLK);

    // Both pressed: no steps, steer frozen.
    left = 2'b01; right = 2'b01;
    repeat (30) @(negedge CLK);
    check("both_frozen_steer", int'(steer[1:0]), int'(gray(ph_m[0])));
    left = '0; right = '0;
    repeat (6) @(negedge CLK);

    // Acceleration run, then re-press restores the base interval.
    clkdiv = 16'd16;
    k = ecount; right = 2'b01;
    for (int i = 0; i < $size(acc_t); i++) push_step(0, k + acc_t[i], 1'b1);
    wait_edge(k + 60); right = '0;
    repeat (10) @(negedge CLK);
    k = ecount; right = 2'b01;
    push_step(0, k + 20, 1'b1);
    wait_edge(k + 20); right = '0;
    repeat (10) @(negedge CLK);

    // Reversal exactly on a due step: suppressed, then CCW at base rate.
    k = ecount; right = 2'b01;
    for (int i = 0; i < $size(rev_t); i++) push_step(0, k + rev_t[i], 1'b1);
    push_step(0, k + 68, 1'b0);
    push_step(0, k + 84, 1'b0);
    wait_edge(k + 48); right = '0; left = 2'b01;
    wait_edge(k + 80); left = '0;
    repeat (10) @(negedge CLK);

    // Two channels concurrently, coincident steps.
    clkdiv = 16'd3;
    k = ecount; right = 2'b01; left = 2'b10;
    sched(0, 1'b1, k + 4, k + 24, 1'b1);
    sched(1, 1'b0, k + 4, k + 24, 1'b1);
    wait_edge(k + 20); right = '0; left = '0;
    repeat (10) @(negedge CLK);

    // clkdiv=0 steps every cycle; step at the release edge still issued.
    clkdiv = 16'd0;
    k = ecount; right = 2'b10;
    for (int i = 5; i <= 10; i++) push_step(1, k + i, 1'b1);
    wait_edge(k + 6); right = '0;
    repeat (10) @(negedge CLK);

    // Asynchronous reset mid-run.
    clkdiv = 16'd2;
    k = ecount; right = 2'b01;
    sched(0, 1'b1, k + 4, k + 12, 1'b1);
    wait_edge(k + 12);
    #2 Reset_n = 1'b0;
    #1;
    check("async_reset_steer", int'(steer), 0);
    check("async_reset_pulse", int'(step_pulse), 0);
    check("pre_reset_q0_empty", evq[0].size(), 0);
    ph_m[0] = '0; ph_m[1] = '0;
    cur_s[0] = '0; cur_s[1] = '0;
    right = '0;
    repeat (2) @(negedge CLK);
    Reset_n = 1'b1;
    repeat (10) @(negedge CLK);
    check("post_reset_steer", int'(steer), 0);

    check("end_q0_empty", evq[0].size(), 0);
    check("end_q1_empty", evq[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
